game_stats: RTL and testbench
=============================

Name: game_stats

Overview:
Score and lives bookkeeping for the game core.
- Consumes single-cycle event pulses from the collision/gameplay logic: alien destroyed, player struck, start pressed.
- Maintains the 0..99 score and the 0..3 lives count that drive the seven-segment display controller directly downstream.
- Also generates the post-hit invulnerability window and the game-over flag used by the sprite and control logic.

Parameters:
- START_LIVES, 3, lives loaded on reset and on game start (1..MAX_LIVES).
- MAX_LIVES, 3, ceiling for the lives count (must fit 2 bits).
- MAX_SCORE, 99, saturation value of the score (must be <= 99 for two-digit display).
- BONUS_SCORE, 50, score threshold that awards one extra life once per game.
- INVULN_TICKS, 60, length of the post-hit invulnerability window, in tick pulses.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle frame enable (timing base for invulnerability)
- game_start  in  1  one-cycle pulse, starts or restarts a game
- alien_hit  in  1  one-cycle pulse, an alien was destroyed
- alien_pts  in  4  points for this alien_hit, 0..15; sampled only when alien_hit=1
- player_hit  in  1  one-cycle pulse, player struck
- score  out  7  current score, 0..MAX_SCORE
- lives  out  2  remaining lives, 0..MAX_LIVES
- playing  out  1  high in PLAYING or INVULN
- invuln  out  1  high in INVULN
- game_over  out  1  high in GAME_OVER
- bonus_pulse  out  1  one-cycle pulse when the extra life is granted

Behaviour:
- Reset is asynchronous to IDLE. Reset values: score=0, lives=START_LIVES, playing=0, invuln=0, game_over=0, bonus_pulse=0, bonus_done=0, inv_cnt=0. Any assertion of rst mid-game aborts immediately to these values.
- All outputs are registered; an event sampled on edge N is visible after edge N.
- States:
  - IDLE: only game_start has effect; all other inputs are ignored.
  - PLAYING.
  - INVULN.
  - GAME_OVER: score and lives hold; all inputs except game_start are ignored.
- game_start in any state → PLAYING with score=0, lives=START_LIVES, bonus_done=0, inv_cnt=0. game_start has priority over every same-cycle event; those events are discarded.
- alien_hit in PLAYING or INVULN:
  - score_next = min(score + alien_pts, MAX_SCORE), computed with an 8-bit intermediate; no wrap.
  - alien_pts=0 leaves the score unchanged.
- Bonus: if bonus_done=0 and score < BONUS_SCORE and score_next >= BONUS_SCORE:
  - set bonus_done=1 and pulse bonus_pulse for one cycle;
  - lives increments only if lives < MAX_LIVES (the bonus is consumed even when capped).
- player_hit in PLAYING:
  - lives_net = lives + bonus_inc - 1, where bonus_inc comes from a same-cycle alien_hit, applied first.
  - lives_net = 0 → GAME_OVER, lives=0.
  - Otherwise → INVULN, inv_cnt=INVULN_TICKS.
- player_hit in INVULN is ignored; alien_hit still scores.
- INVULN timing:
  - inv_cnt decrements on each tick.
  - A tick with inv_cnt=1 → PLAYING, inv_cnt=0, invuln deasserts on the following edge.
  - Window length is exactly INVULN_TICKS ticks.
- Score saturation: at MAX_SCORE, further hits hold 99 with no wrap and no second bonus.

Decomposition:
- Shared package game_pkg:
  - state enum {IDLE, PLAYING, INVULN, GAME_OVER};
  - SCORE_W=7, LIVES_W=2, DISPLAY_MAX_SCORE=99 constants, shared with the seven-segment controller.
- One sub-module, invuln_timer:
  - loadable down-counter with tick enable;
  - inputs load and tick; outputs active and expire pulse;
  - width $clog2(INVULN_TICKS+1).

Test Plan:
- Reset then game_start → playing=1, score=0, lives=3. alien_hit with pts 7 ×3 → score 7, 14, 21, each one cycle after its pulse.
- Score 95, alien_hit pts 10 → score=99; further hit pts 15 → score stays 99, no wrap.
- Score 45, lives 2, alien_hit pts 5 → score=50, lives=3, one bonus_pulse. Drop to 40 via restart-free path: not possible, so continue to 99 → no second bonus_pulse.
- Lives 3, player_hit → lives=2, invuln=1.
  - Further player_hit during window → lives stays 2.
  - Exactly 60 ticks later invuln=0; the next player_hit → lives=1.
- Lives 1, alien_hit (crossing 50) and player_hit in the same cycle → lives=1, state INVULN, bonus_pulse=1. Lives 1, player_hit alone → lives=0, game_over=1; further alien_hit → score unchanged.
- Assert rst asynchronously mid-INVULN (between clock edges) → outputs at reset values immediately. game_start together with player_hit → lives=3, state PLAYING.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-core definitions: FSM state encoding and the display-facing
// widths used by both the stats block and the seven-segment controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int SCORE_W           = 7;
  localparam int LIVES_W           = 2;
  localparam int DISPLAY_MAX_SCORE = 99;

endpackage

// File: rtl/game_stats_invuln_timer.sv
// Post-hit invulnerability timer: loadable down-counter advanced by the frame
// tick. expire pulses combinationally on the tick that empties the counter so
// the owning FSM can leave its invulnerable state on that same edge.
module invuln_timer #(
  parameter int INVULN_TICKS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic active,
  output logic expire
);

  localparam int                CNT_W    = $clog2(INVULN_TICKS + 1);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(INVULN_TICKS);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign active = (cnt != '0);
  // A clear or reload on the same cycle supersedes the final tick.
  assign expire = tick && (cnt == ONE) && !load && !clear;

  // Down-counter: clear beats load, load beats tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && active) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/game_stats.sv
// Score / lives bookkeeping for the game core. Turns single-cycle gameplay
// events into the saturating 0..MAX_SCORE score, the lives count, the one-time
// extra-life bonus, the post-hit invulnerability window and game-over flag.
module game_stats
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 3,
  parameter int MAX_SCORE    = 99,
  parameter int BONUS_SCORE  = 50,
  parameter int INVULN_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               game_start,
  input  logic               alien_hit,
  input  logic [3:0]         alien_pts,
  input  logic               player_hit,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               invuln,
  output logic               game_over,
  output logic               bonus_pulse
);

  localparam logic [7:0]         MAX_SCORE_8 = 8'(MAX_SCORE);
  localparam logic [7:0]         BONUS_8     = 8'(BONUS_SCORE);
  localparam logic [2:0]         MAX_LIVES_3 = 3'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] START_L     = LIVES_W'(START_LIVES);

  // Clamp the widened sum so the score never wraps past the display limit.
  function automatic logic [7:0] sat_score(input logic [7:0] sum);
    return (sum > MAX_SCORE_8) ? MAX_SCORE_8 : sum;
  endfunction

  state_t     state, state_next;
  logic       bonus_done;
  logic [7:0] score_sum, score_sat;
  logic [2:0] lives_bonus, lives_net;
  logic       in_game, scoring, bonus_fire, bonus_inc, hit_take;
  logic       timer_load, timer_active, timer_expire;

  invuln_timer #(.INVULN_TICKS(INVULN_TICKS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (game_start),
    .load   (timer_load),
    .tick   (tick),
    .active (timer_active),
    .expire (timer_expire)
  );

  // Event arithmetic: the bonus life is applied before a same-cycle player hit.
  always_comb begin
    in_game     = (state == PLAYING) || (state == INVULN);
    scoring     = alien_hit && in_game;
    score_sum   = {1'b0, score} + {4'b0, alien_pts};
    score_sat   = sat_score(score_sum);
    bonus_fire  = scoring && !bonus_done &&
                  ({1'b0, score} < BONUS_8) && (score_sat >= BONUS_8);
    bonus_inc   = bonus_fire && ({1'b0, lives} < MAX_LIVES_3);
    lives_bonus = {1'b0, lives} + {2'b0, bonus_inc};
    hit_take    = player_hit && (state == PLAYING);
    lives_net   = lives_bonus - {2'b0, hit_take};
    timer_load  = hit_take && (lives_net != 3'd0) && !game_start;
  end

  // Next-state selection; game_start overrides everything else.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      state_next = IDLE;
      PLAYING:   if (hit_take) state_next = (lives_net == 3'd0) ? GAME_OVER : INVULN;
      INVULN:    if (timer_expire || !timer_active) state_next = PLAYING;
      GAME_OVER: state_next = GAME_OVER;
    endcase
    if (game_start) state_next = PLAYING;
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      score       <= '0;
      lives       <= START_L;
      bonus_done  <= 1'b0;
      bonus_pulse <= 1'b0;
      playing     <= 1'b0;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_next;
      playing     <= (state_next == PLAYING) || (state_next == INVULN);
      invuln      <= (state_next == INVULN);
      game_over   <= (state_next == GAME_OVER);
      bonus_pulse <= bonus_fire && !game_start;
      if (game_start) begin
        score      <= '0;
        lives      <= START_L;
        bonus_done <= 1'b0;
      end else if (in_game) begin
        if (scoring)    score      <= score_sat[SCORE_W-1:0];
        if (bonus_fire) bonus_done <= 1'b1;
        lives <= lives_net[LIVES_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_game_stats.sv
// Directed bench for game_stats: a behavioural reference model tracks the game
// rules with plain integers and is compared every cycle; literal checks pin
// the key values from the bring-up scenarios.
module tb_game_stats;

  localparam int M_IDLE = 0, M_PLAY = 1, M_INV = 2, M_OVER = 3;

  typedef struct {
    int mode;
    int score;
    int lives;
    int bd;
    int inv;
    int bp;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, game_start = 1'b0, alien_hit = 1'b0, player_hit = 1'b0;
  logic [3:0] alien_pts = 4'd0;
  logic [6:0] score;
  logic [1:0] lives;
  logic       playing, invuln, game_over, bonus_pulse;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  mdl_t m;

  game_stats dut (
    .clk(clk), .rst(rst), .tick(tick), .game_start(game_start),
    .alien_hit(alien_hit), .alien_pts(alien_pts), .player_hit(player_hit),
    .score(score), .lives(lives), .playing(playing), .invuln(invuln),
    .game_over(game_over), .bonus_pulse(bonus_pulse)
  );

  always #5 clk = ~clk;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.mode = M_IDLE; r.score = 0; r.lives = 3; r.bd = 0; r.inv = 0; r.bp = 0;
    return r;
  endfunction

  // Game rules applied to one sampled set of inputs.
  function automatic mdl_t model_step(mdl_t c, bit gs, bit ah, int pts, bit ph, bit tk);
    mdl_t r = c;
    int   nxt;
    r.bp = 0;
    if (gs) begin
      r.mode = M_PLAY; r.score = 0; r.lives = 3; r.bd = 0; r.inv = 0;
      return r;
    end
    if ((c.mode == M_PLAY || c.mode == M_INV) && ah) begin
      nxt = (c.score + pts > 99) ? 99 : c.score + pts;
      if (c.bd == 0 && c.score < 50 && nxt >= 50) begin
        r.bd = 1;
        r.bp = 1;
        if (r.lives < 3) r.lives = r.lives + 1;
      end
      r.score = nxt;
    end
    if (c.mode == M_PLAY && ph) begin
      r.lives = r.lives - 1;
      if (r.lives == 0) r.mode = M_OVER;
      else begin
        r.mode = M_INV;
        r.inv  = 60;
      end
    end else if (c.mode == M_INV && tk) begin
      r.inv = r.inv - 1;
      if (r.inv == 0) r.mode = M_PLAY;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, game_start, alien_hit, int'(alien_pts), player_hit, tick);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_score", int'(score), m.score);
      check("mdl_lives", int'(lives), m.lives);
      check("mdl_playing", int'(playing), int'(m.mode == M_PLAY || m.mode == M_INV));
      check("mdl_invuln", int'(invuln), int'(m.mode == M_INV));
      check("mdl_game_over", int'(game_over), int'(m.mode == M_OVER));
      check("mdl_bonus_pulse", int'(bonus_pulse), m.bp);
    end
  end

  // One clock of stimulus, returning at the following falling edge.
  task automatic step(input bit gs, input bit ah, input int pts, input bit ph, input bit tk);
    game_start = gs; alien_hit = ah; alien_pts = 4'(pts); player_hit = ph; tick = tk;
    @(posedge clk);
    #1;
    game_start = 1'b0; alien_hit = 1'b0; alien_pts = 4'd0; player_hit = 1'b0; tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_score", int'(score), 0);
    check("reset_lives", int'(lives), 3);
    check("reset_playing", int'(playing), 0);

    // Game A: scoring cadence, first hit and the invulnerability window.
    step(1, 0, 0, 0, 0);
    check("start_playing", int'(playing), 1);
    step(0, 1, 7, 0, 0); check("score_7", int'(score), 7);
    step(0, 1, 7, 0, 0); check("score_14", int'(score), 14);
    step(0, 1, 7, 0, 0); check("score_21", int'(score), 21);
    step(0, 0, 0, 1, 0);
    check("hit_lives_2", int'(lives), 2);
    check("hit_invuln", int'(invuln), 1);
    step(0, 0, 0, 1, 0); check("hit_ignored", int'(lives), 2);
    step(0, 0, 0, 0, 0);
    ticks(59);
    check("window_59", int'(invuln), 1);
    step(0, 0, 0, 0, 0);
    check("window_no_tick", int'(invuln), 1);
    ticks(1);
    check("window_60", int'(invuln), 0);
    step(0, 1, 15, 0, 0);
    step(0, 1, 9, 0, 0); check("score_45", int'(score), 45);
    step(0, 1, 5, 0, 0);
    check("bonus_score", int'(score), 50);
    check("bonus_lives", int'(lives), 3);
    check("bonus_pulse", int'(bonus_pulse), 1);
    step(0, 0, 0, 0, 0); check("bonus_once", int'(bonus_pulse), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 15, 0, 0);
    check("score_95", int'(score), 95);
    step(0, 1, 10, 0, 0); check("sat_99", int'(score), 99);
    step(0, 1, 15, 0, 0); check("sat_hold", int'(score), 99);
    check("no_second_bonus", int'(bonus_pulse), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0); ticks(60);
    step(0, 0, 0, 1, 0); check("next_hit_lives_1", int'(lives), 1);
    ticks(60);

    // Game B: bonus and hit together, then game over.
    step(1, 0, 0, 0, 0); check("restart_lives", int'(lives), 3);
    step(0, 0, 0, 1, 0); ticks(60);
    step(0, 0, 0, 1, 0); ticks(60);
    for (int i = 0; i < 3; i++) step(0, 1, 15, 0, 0);
    step(0, 1, 5, 1, 0);
    check("combo_lives", int'(lives), 1);
    check("combo_invuln", int'(invuln), 1);
    check("combo_bonus", int'(bonus_pulse), 1);
    ticks(60);
    step(0, 0, 0, 1, 0);
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    step(0, 1, 7, 0, 0); check("over_score_hold", int'(score), 50);
    step(0, 0, 0, 1, 1);

    // Game C: asynchronous abort mid-window, then start beats a hit.
    step(1, 0, 0, 0, 0);
    step(0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 0);
    ticks(5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_score", int'(score), 0);
    check("async_lives", int'(lives), 3);
    check("async_invuln", int'(invuln), 0);
    check("async_playing", int'(playing), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 9, 1, 1); check("idle_ignores", int'(score), 0);
    step(1, 0, 0, 1, 0);
    check("start_prio_lives", int'(lives), 3);
    check("start_prio_playing", int'(playing), 1);
    check("start_prio_invuln", int'(invuln), 0);
    step(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
